// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// crc_pkg : shared types, presets and bit-level helpers for the CRC engine
// Rev 1.0
// ============================================================================
package crc_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } crc_state_e;

  typedef struct packed {
    logic [6:0]  width;
    logic [63:0] poly;
    logic [63:0] init;
    logic        refin;
    logic        refout;
    logic [63:0] xorout;
  } crc_preset_t;

  localparam crc_preset_t CRC8_PRESET = '{
    width: 7'd8, poly: 64'h07, init: 64'h00,
    refin: 1'b0, refout: 1'b0, xorout: 64'h00
  };

  localparam crc_preset_t CRC16_CCITT_FALSE_PRESET = '{
    width: 7'd16, poly: 64'h1021, init: 64'hFFFF,
    refin: 1'b0, refout: 1'b0, xorout: 64'h0000
  };

  localparam crc_preset_t CRC32_PRESET = '{
    width: 7'd32, poly: 64'h04C1_1DB7, init: 64'hFFFF_FFFF,
    refin: 1'b1, refout: 1'b1, xorout: 64'hFFFF_FFFF
  };

  // Reverse the low w bits of v; bits at and above w come back zero.
  function automatic logic [63:0] rev_bits(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[6'(i)] = v[6'(w - 1 - i)];
    end
    return r;
  endfunction

  // data_w serial MSB-first shifts of a crc_w-bit register, result masked to crc_w.
  function automatic logic [63:0] crc_step(input logic [63:0] crc,
                                           input logic [63:0] data,
                                           input logic [63:0] poly,
                                           input int          crc_w,
                                           input int          data_w);
    logic [63:0] r;
    logic        fb;
    r = crc;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < data_w) begin
        fb = r[6'(crc_w - 1)] ^ data[6'(data_w - 1 - i)];
        r  = {r[62:0], 1'b0};
        if (fb) r = r ^ poly;
      end
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= crc_w) r[6'(i)] = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_next_comb.sv
`default_nettype none
// ============================================================================
// crc_next_comb : combinational CRC register update for one DATA_W input word
// Rev 1.0
// ============================================================================
module crc_next_comb
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07)
) (
  input  logic [CRC_W-1:0]  base,
  input  logic [DATA_W-1:0] word,
  output logic [CRC_W-1:0]  next
);

  always_comb begin
    next = CRC_W'(crc_step(64'(base), 64'(word), 64'(POLY), CRC_W, DATA_W));
  end

endmodule
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// crc_stream_engine : streaming parametrised CRC with valid/ready input and held result
// Rev 1.0
// ============================================================================
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              busy
);

  crc_state_e        state_q, state_d;
  logic [CRC_W-1:0]  crc_reg_q, crc_reg_d;
  logic              crc_valid_q, crc_valid_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;

  logic              accept;
  logic [DATA_W-1:0] word_in;
  logic [CRC_W-1:0]  step_base;
  logic [CRC_W-1:0]  step_next;
  logic [CRC_W-1:0]  final_crc;

  assign in_ready = ~clear & ((state_q != ST_HOLD) | crc_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == ST_ACCUM);
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;

  assign word_in   = REFIN ? DATA_W'(rev_bits(64'(in_data), DATA_W)) : in_data;
  // Only a frame in progress continues from the register; IDLE and a draining HOLD restart.
  assign step_base = (state_q == ST_ACCUM) ? crc_reg_q : INIT;

  crc_next_comb #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_next (
    .base (step_base),
    .word (word_in),
    .next (step_next)
  );

  assign final_crc = (REFOUT ? CRC_W'(rev_bits(64'(step_next), CRC_W)) : step_next) ^ XOROUT;

  always_comb begin
    state_d     = state_q;
    crc_reg_d   = crc_reg_q;
    crc_valid_d = crc_valid_q;
    crc_out_d   = crc_out_q;

    if (clear) begin
      state_d     = ST_IDLE;
      crc_reg_d   = INIT;
      crc_valid_d = 1'b0;
      crc_out_d   = '0;
    end else begin
      if ((state_q == ST_HOLD) && crc_ready) begin
        state_d     = ST_IDLE;
        crc_valid_d = 1'b0;
      end
      // A word accepted while HOLD drains starts the next frame in the same cycle.
      if (accept) begin
        crc_reg_d = step_next;
        if (in_last) begin
          state_d     = ST_HOLD;
          crc_valid_d = 1'b1;
          crc_out_d   = final_crc;
        end else begin
          state_d = ST_ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_reg_q   <= INIT;
      crc_valid_q <= 1'b0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_reg_q   <= crc_reg_d;
      crc_valid_q <= crc_valid_d;
      crc_out_q   <= crc_out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_crc_stream_engine : directed vector bench over CRC-8/16/16x16/32 instances
// Rev 1.0
// ============================================================================
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_last = 1'b0;
  logic        crc_ready = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_valid = 4'h0;
  logic [3:0]  in_ready;
  logic [3:0]  crc_valid;
  logic [3:0]  busy;
  logic [7:0]  out0;
  logic [15:0] out1;
  logic [15:0] out2;
  logic [31:0] out3;
  logic [63:0] crc_out_w [4];

  int n_pass = 0;
  int n_total = 0;

  assign crc_out_w[0] = 64'(out0);
  assign crc_out_w[1] = 64'(out1);
  assign crc_out_w[2] = 64'(out2);
  assign crc_out_w[3] = 64'(out3);

  always #5 clk = ~clk;

  crc_stream_engine #(
    .CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00),
    .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(8'h00)
  ) u_crc8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[7:0]),
    .in_last(in_last), .crc_valid(crc_valid[0]), .crc_ready(crc_ready),
    .crc_out(out0), .busy(busy[0])
  );

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
    .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
  ) u_crc16 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[7:0]),
    .in_last(in_last), .crc_valid(crc_valid[1]), .crc_ready(crc_ready),
    .crc_out(out1), .busy(busy[1])
  );

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
    .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
  ) u_crc16w (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
    .in_last(in_last), .crc_valid(crc_valid[2]), .crc_ready(crc_ready),
    .crc_out(out2), .busy(busy[2])
  );

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(8), .POLY(32'h04C1_1DB7), .INIT(32'hFFFF_FFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFF_FFFF)
  ) u_crc32 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[7:0]),
    .in_last(in_last), .crc_valid(crc_valid[3]), .crc_ready(crc_ready),
    .crc_out(out3), .busy(busy[3])
  );

  typedef struct {
    logic [1:0]  inst;
    string       msg;
    int          wb;
    bit          gaps;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [6];

  // Byte-wise CRC-16/CCITT-FALSE reference (xor byte into the top, then 8 shifts).
  function automatic logic [15:0] golden16(input string s);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < s.len(); i++) begin
      c = c ^ {s[i], 8'h00};
      for (int b = 0; b < 8; b++) begin
        if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
        else       c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a word from a negedge and hold it until the posedge that accepts it.
  task automatic send(input logic [1:0] k, input logic [15:0] d, input logic last);
    int n;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data     = d;
    in_last     = last;
    #1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(in_ready[k]), 64'd1);
    if (last) check("no_early_valid", 64'(crc_valid[k]), 64'd0);
    @(posedge clk);
  endtask

  task automatic run_frame(input logic [1:0] k, input string s, input int wb,
                           input bit gaps, input logic [63:0] exp, input string name);
    int nw;
    nw = s.len() / wb;
    for (int i = 0; i < nw; i++) begin
      logic [15:0] d;
      d = (wb == 2) ? {s[2*i], s[2*i+1]} : {8'h00, s[i]};
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          in_valid[k] = 1'b0;
        end
      end
      send(k, d, (i == nw - 1));
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_last     = 1'b0;
    check({name, "_valid"}, 64'(crc_valid[k]), 64'd1);
    check({name, "_crc"}, crc_out_w[k], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string s9;
    s9 = "123456789";
    vecs[0] = '{inst: 2'd0, msg: "123456789", wb: 1, gaps: 1'b0, exp: 64'hF4,        name: "crc8"};
    vecs[1] = '{inst: 2'd1, msg: "123456789", wb: 1, gaps: 1'b0, exp: 64'h29B1,      name: "crc16"};
    vecs[2] = '{inst: 2'd3, msg: "123456789", wb: 1, gaps: 1'b0, exp: 64'hCBF43926,  name: "crc32"};
    vecs[3] = '{inst: 2'd2, msg: "12345678",  wb: 2, gaps: 1'b0, exp: 64'(golden16("12345678")), name: "crc16w"};
    vecs[4] = '{inst: 2'd1, msg: "12345678",  wb: 1, gaps: 1'b0, exp: 64'(golden16("12345678")), name: "crc16_8b"};
    vecs[5] = '{inst: 2'd0, msg: "123456789", wb: 1, gaps: 1'b1, exp: 64'hF4,        name: "crc8_gaps"};

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(crc_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    for (int k = 0; k < 4; k++) check("rst_crc_out", crc_out_w[k], 64'h0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'hF);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].inst, vecs[v].msg, vecs[v].wb, vecs[v].gaps, vecs[v].exp, vecs[v].name);
      @(negedge clk);
      check({vecs[v].name, "_drained"}, 64'(crc_valid[vecs[v].inst]), 64'd0);
    end

    // Backpressure, then a single-word frame accepted in the draining cycle.
    crc_ready = 1'b0;
    run_frame(2'd0, s9, 1, 1'b0, 64'hF4, "bp_frame");
    in_valid[0] = 1'b1;
    in_data     = 16'h0031;
    in_last     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check("bp_crc_stable", crc_out_w[0], 64'hF4);
      check("bp_valid_held", 64'(crc_valid[0]), 64'd1);
      @(negedge clk);
    end
    crc_ready = 1'b1;
    #1;
    check("bp_ready_release", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_last     = 1'b0;
    check("b2b_valid", 64'(crc_valid[0]), 64'd1);
    check("b2b_crc", crc_out_w[0], 64'h97);
    check("b2b_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    check("b2b_drained", 64'(crc_valid[0]), 64'd0);

    // Abort after four words.
    for (int i = 0; i < 4; i++) send(2'd0, {8'h00, s9[i]}, 1'b0);
    @(negedge clk);
    clear       = 1'b1;
    in_valid[0] = 1'b1;
    in_data     = {8'h00, s9[4]};
    #1;
    check("clr_busy_before", 64'(busy[0]), 64'd1);
    check("clr_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    clear       = 1'b0;
    in_valid[0] = 1'b0;
    check("clr_busy_after", 64'(busy[0]), 64'd0);
    check("clr_valid_after", 64'(crc_valid[0]), 64'd0);
    run_frame(2'd0, s9, 1, 1'b0, 64'hF4, "post_clear");
    @(negedge clk);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) send(2'd0, {8'h00, s9[i]}, 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("mid_busy", 64'(busy[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_busy", 64'(busy[0]), 64'd0);
    check("arst_mid_valid", 64'(crc_valid[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is held.
    crc_ready = 1'b0;
    run_frame(2'd0, s9, 1, 1'b0, 64'hF4, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 64'(crc_valid[0]), 64'd0);
    check("arst_hold_crc", crc_out_w[0], 64'h0);
    check("arst_hold_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    crc_ready = 1'b1;
    run_frame(2'd0, "1", 1, 1'b0, 64'h97, "single");
    @(negedge clk);
    check("single_drained", 64'(crc_valid[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
